// File: rtl/float_round_pack_pkg.sv
// Shared types and constants for the binary32 round/pack stage and its helpers.
package float_round_pack_pkg;

  localparam int          BIAS       = 127;
  localparam int          SHIFT_MAX  = 26;
  localparam logic [7:0]  EXP_INF    = 8'hFF;
  localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;
  localparam logic [31:0] CANON_NAN  = 32'h7FC00000;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

endpackage

// File: rtl/float_round_pack_if.sv
// Result-bundle handshake between an FPU op unit, the round/pack stage and writeback.
interface float_round_pack_if;
  logic        valid_in;
  logic        ready_out;
  logic [23:0] man_in;
  logic [9:0]  exp_in;
  logic        sgn_in;
  logic        round_bit;
  logic        sticky_bit;
  logic        skip_round;
  logic        IV;
  logic        DZ;
  logic [2:0]  rm;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] float_out;
  logic [4:0]  fflags;

  modport slave (
    input  valid_in, man_in, exp_in, sgn_in, round_bit, sticky_bit,
           skip_round, IV, DZ, rm, ready_in,
    output ready_out, valid_out, float_out, fflags
  );

  modport master (
    output valid_in, man_in, exp_in, sgn_in, round_bit, sticky_bit,
           skip_round, IV, DZ, rm, ready_in,
    input  ready_out, valid_out, float_out, fflags
  );
endinterface

// File: rtl/float_round_inc.sv
// Round-increment decision from rounding mode, sign, LSB and round/sticky bits.
module float_round_inc
  import float_round_pack_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sgn,
  input  logic       lsb,
  input  logic       r,
  input  logic       s,
  output logic       inc
);

  // Reserved encodings fall through to round-to-nearest-even.
  always_comb begin
    inc = r & (s | lsb);
    case (rm_e'(rm))
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sgn & (r | s);
      RM_RUP:  inc = ~sgn & (r | s);
      RM_RMM:  inc = r;
      default: inc = r & (s | lsb);
    endcase
  end

endmodule

// File: rtl/float_round_pack.sv
// Two-stage binary32 finisher: denormalise, then round, saturate and pack with flags.
module float_round_pack #(
  parameter int BIAS      = float_round_pack_pkg::BIAS,
  parameter int SHIFT_MAX = float_round_pack_pkg::SHIFT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  float_round_pack_if.slave bus
);
  import float_round_pack_pkg::*;

  logic        v1, v2, adv2, accept;
  logic [23:0] m1;
  logic [7:0]  e1;
  logic        r1, s1, tiny1, ovf1, sgn1, skip1, iv1, dz1;
  logic [2:0]  rm1;
  logic [31:0] out_q;
  fflags_t     flags_q;

  assign adv2          = ~v2 | bus.ready_in;
  assign bus.ready_out = ~v1 | adv2;
  assign accept        = bus.valid_in & bus.ready_out;
  assign bus.valid_out = v2;
  assign bus.float_out = out_q;
  assign bus.fflags    = flags_q;

  logic signed [10:0] e_s, sh_full;
  logic [10:0]        sh;
  logic               den;
  logic [50:0]        shifted;

  assign e_s     = $signed({bus.exp_in[9], bus.exp_in}) + $signed(11'(BIAS));
  assign den     = (e_s <= 11'sd0);
  assign sh_full = 11'sd1 - e_s;
  assign sh      = (sh_full > $signed(11'(SHIFT_MAX))) ? 11'(SHIFT_MAX) : sh_full;
  // Room below the round bit collects every discarded bit for the sticky OR.
  assign shifted = {bus.man_in, bus.round_bit, 26'd0} >> sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; m1 <= '0; e1 <= '0; r1 <= 1'b0; s1 <= 1'b0;
      tiny1 <= 1'b0; ovf1 <= 1'b0; sgn1 <= 1'b0; skip1 <= 1'b0;
      iv1 <= 1'b0; dz1 <= 1'b0; rm1 <= '0;
    end else begin
      if (bus.ready_out) v1 <= bus.valid_in;
      if (accept) begin
        sgn1 <= bus.sgn_in; rm1 <= bus.rm; skip1 <= bus.skip_round;
        iv1  <= bus.IV;     dz1 <= bus.DZ;
        if (bus.skip_round) begin
          m1 <= bus.man_in; r1 <= 1'b0; s1 <= 1'b0;
          e1 <= bus.exp_in[7:0]; tiny1 <= 1'b0; ovf1 <= 1'b0;
        end else if (den) begin
          m1 <= shifted[50:27]; r1 <= shifted[26];
          s1 <= (|shifted[25:0]) | bus.sticky_bit;
          e1 <= 8'd0; tiny1 <= 1'b1; ovf1 <= 1'b0;
        end else begin
          m1 <= bus.man_in; r1 <= bus.round_bit; s1 <= bus.sticky_bit;
          e1 <= e_s[7:0]; tiny1 <= 1'b0; ovf1 <= (e_s >= 11'sd255);
        end
      end
    end
  end

  logic        inc;
  logic [24:0] m_sum;
  logic [8:0]  exp_r;
  logic [22:0] frac_r;
  logic [30:0] ovf_mag;
  logic [31:0] result;
  fflags_t     flags;

  float_round_inc u_inc (
    .rm(rm1), .sgn(sgn1), .lsb(m1[0]), .r(r1), .s(s1), .inc(inc)
  );

  assign m_sum = {1'b0, m1} + {24'd0, inc};

  always_comb begin
    exp_r  = {1'b0, e1};
    frac_r = m_sum[22:0];
    if (m_sum[24]) begin
      exp_r  = {1'b0, e1} + 9'd1;
      frac_r = m_sum[23:1];
    end else if (e1 == 8'd0 && m_sum[23]) begin
      exp_r = 9'd1;   // subnormal rounded up into the smallest normal
    end
    ovf_mag = {EXP_INF, 23'd0};
    case (rm_e'(rm1))
      RM_RTZ:  ovf_mag = MAX_FINITE;
      RM_RDN:  ovf_mag = sgn1 ? {EXP_INF, 23'd0} : MAX_FINITE;
      RM_RUP:  ovf_mag = sgn1 ? MAX_FINITE : {EXP_INF, 23'd0};
      default: ovf_mag = {EXP_INF, 23'd0};
    endcase
    flags    = '0;
    flags.nv = iv1;
    flags.dz = dz1;
    if (skip1) begin
      result = {sgn1, e1, m1[22:0]};
    end else begin
      flags.of = ovf1 | (exp_r >= 9'd255);
      flags.nx = r1 | s1 | flags.of;
      flags.uf = tiny1 & flags.nx;
      result   = flags.of ? {sgn1, ovf_mag} : {sgn1, exp_r[7:0], frac_r};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2      <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_q   <= result;
        flags_q <= flags;
      end
    end
  end

endmodule

// File: tb/tb_float_round_pack.sv
// Randomised and directed bench for float_round_pack against an arithmetic rounding model.
module tb_float_round_pack;
  import float_round_pack_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  logic took   = 1'b0;
  logic [36:0] q[$];

  always #5 clk = ~clk;

  float_round_pack_if bus();

  float_round_pack dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [23:0] man;
    logic [9:0]  ex;
    logic        sg, r, s, sk, iv, dz;
    logic [2:0]  rm;
  } txn_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Value treated as an integer scaled by 2^31 (plus sticky), then divided down to the result ulp.
  function automatic logic [36:0] model(input logic [23:0] man, input logic [9:0] ex,
                                        input logic sg, input logic r, input logic s,
                                        input logic sk, input logic iv, input logic dz,
                                        input logic [2:0] rmv);
    int e, k;
    longint unsigned w, dv, half, qv, rem, mag;
    logic incv, of, nx, uf, tiny;
    if (sk) return {sg, ex[7:0], man[22:0], iv, dz, 3'b000};
    e    = int'($signed(ex)) + 127;
    tiny = (e <= 0);
    k    = tiny ? (((1 - e) > 26) ? 26 : (1 - e)) : 0;
    w    = (longint'(man) << 31) | (longint'(r) << 30) | longint'(s);
    dv   = 64'd1 << (31 + k);
    half = 64'd1 << (30 + k);
    qv   = w / dv;
    rem  = w % dv;
    case (rmv)
      3'd1:    incv = 1'b0;
      3'd2:    incv = sg && (rem != 0);
      3'd3:    incv = !sg && (rem != 0);
      3'd4:    incv = (rem >= half);
      default: incv = (rem > half) || ((rem == half) && qv[0]);
    endcase
    qv = qv + longint'(incv);
    mag = 0;
    if (!tiny && e >= 255) of = 1'b1;
    else begin
      mag = (longint'(tiny ? 0 : e - 1) << 23) + qv;
      of  = (mag >= 64'h7F800000);
    end
    if (of) begin
      case (rmv)
        3'd1:    mag = 64'h7F7FFFFF;
        3'd2:    mag = sg ? 64'h7F800000 : 64'h7F7FFFFF;
        3'd3:    mag = sg ? 64'h7F7FFFFF : 64'h7F800000;
        default: mag = 64'h7F800000;
      endcase
    end
    nx = (rem != 0) || of;
    uf = tiny && nx;
    return {sg, mag[30:0], iv, dz, of, uf, nx};
  endfunction

  function automatic txn_t gen();
    txn_t t;
    int   cls;
    t.man = {1'b1, 23'($urandom)};
    t.sg  = 1'($urandom_range(0, 1));
    t.r   = 1'($urandom_range(0, 1));
    t.s   = 1'($urandom_range(0, 1));
    t.sk  = 1'b0;
    t.iv  = ($urandom_range(0, 15) == 0);
    t.dz  = ($urandom_range(0, 15) == 0);
    t.rm  = 3'($urandom_range(0, 7));
    cls   = int'($urandom_range(0, 9));
    if (cls <= 4)      t.ex = 10'(int'($urandom_range(0, 253)) - 126);
    else if (cls <= 6) begin
      t.ex  = 10'(-127 - int'($urandom_range(0, 50)));
      t.man = 24'($urandom);
    end
    else if (cls == 7) t.ex = 10'(120 + int'($urandom_range(0, 15)));
    else if (cls == 8) begin
      t.ex  = 10'd127;
      t.man = 24'hFFFFFF - 24'($urandom_range(0, 3));
    end else begin
      t.sk  = 1'b1;
      t.ex  = 10'($urandom);
      t.man = 24'($urandom);
    end
    return t;
  endfunction

  task automatic drive(input txn_t t);
    bus.man_in = t.man; bus.exp_in = t.ex; bus.sgn_in = t.sg;
    bus.round_bit = t.r; bus.sticky_bit = t.s; bus.skip_round = t.sk;
    bus.IV = t.iv; bus.DZ = t.dz; bus.rm = t.rm;
  endtask

  task automatic directed(input string nm, input logic [23:0] man, input logic [9:0] ex,
                          input logic sg, input logic r, input logic s, input logic sk,
                          input logic iv, input logic [2:0] rmv,
                          input logic [31:0] ef, input logic [4:0] efl);
    txn_t t;
    int   cnt;
    chk({nm, "_model"}, 64'(model(man, ex, sg, r, s, sk, iv, 1'b0, rmv)), 64'({ef, efl}));
    t = '{man: man, ex: ex, sg: sg, r: r, s: s, sk: sk, iv: iv, dz: 1'b0, rm: rmv};
    bus.ready_in = 1'b1;
    drive(t);
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    cnt = 1;
    while (!bus.valid_out && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, "_latency"}, 64'(cnt), 64'd2);
    chk({nm, "_result"}, 64'({bus.float_out, bus.fflags}), 64'({ef, efl}));
  endtask

  // Scoreboard: expectations enter on transfer-in, leave on transfer-out.
  initial begin
    logic        held_v;
    logic [36:0] held, e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        q.delete();
        held_v = 1'b0;
        took <= 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", 64'(bus.valid_out), 64'd1);
          chk("hold_data", 64'({bus.float_out, bus.fflags}), 64'(held));
        end
        held_v = bus.valid_out && !bus.ready_in;
        held   = {bus.float_out, bus.fflags};
        if (bus.valid_out && bus.ready_in) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected no output", {bus.float_out, bus.fflags});
          end else begin
            e = q.pop_front();
            chk("scoreboard", 64'({bus.float_out, bus.fflags}), 64'(e));
          end
          pops <= pops + 1;
        end
        took <= bus.valid_in && bus.ready_out;
        if (bus.valid_in && bus.ready_out)
          q.push_back(model(bus.man_in, bus.exp_in, bus.sgn_in, bus.round_bit, bus.sticky_bit,
                            bus.skip_round, bus.IV, bus.DZ, bus.rm));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, guard, p0;
    reset = 1'b0;
    bus.valid_in = 1'b0; bus.ready_in = 1'b0;
    drive('0);
    #12;
    chk("reset_valid_out", 64'(bus.valid_out), 64'd0);
    chk("reset_float_out", 64'(bus.float_out), 64'd0);
    chk("reset_fflags", 64'(bus.fflags), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    directed("exact",      24'h800000, 10'd1,         0, 0, 0, 0, 0, 3'd0, 32'h40000000, 5'h00);
    directed("carry_rne",  24'hFFFFFF, 10'd0,         0, 1, 0, 0, 0, 3'd0, 32'h40000000, 5'h01);
    directed("carry_rtz",  24'hFFFFFF, 10'd0,         0, 1, 0, 0, 0, 3'd1, 32'h3FFFFFFF, 5'h01);
    directed("ovf_rtz",    24'h800000, 10'd128,       0, 0, 0, 0, 0, 3'd1, 32'h7F7FFFFF, 5'h05);
    directed("ovf_rne",    24'h800000, 10'd128,       0, 0, 0, 0, 0, 3'd0, 32'h7F800000, 5'h05);
    directed("ovf_rup_n",  24'h800000, 10'd128,       1, 0, 0, 0, 0, 3'd3, 32'hFF7FFFFF, 5'h05);
    directed("sub_exact",  24'h800000, 10'(-127),     0, 0, 0, 0, 0, 3'd0, 32'h00400000, 5'h00);
    directed("sub_rup",    24'h800000, 10'(-127),     0, 0, 1, 0, 0, 3'd3, 32'h00400001, 5'h03);
    directed("sub_to_min", 24'hFFFFFF, 10'(-127),     0, 1, 0, 0, 0, 3'd0, 32'h00800000, 5'h03);
    directed("sub_clamp",  24'hFFFFFF, 10'(-200),     0, 1, 0, 0, 0, 3'd3, 32'h00000001, 5'h03);
    directed("tie_rne",    24'h800000, 10'd0,         0, 1, 0, 0, 0, 3'd0, 32'h3F800000, 5'h01);
    directed("tie_rmm",    24'h800000, 10'd0,         0, 1, 0, 0, 0, 3'd4, 32'h3F800001, 5'h01);
    directed("tie_rm5",    24'h800001, 10'd0,         0, 1, 0, 0, 0, 3'd5, 32'h3F800002, 5'h01);
    directed("skip_nan",   24'hC00000, 10'h0FF,       0, 0, 0, 1, 1, 3'd0, CANON_NAN,    5'h10);
    directed("skip_zero",  24'h000000, 10'd0,         1, 1, 1, 1, 0, 3'd0, 32'h80000000, 5'h00);

    // Backpressure: only two bundles fit while the sink stalls.
    @(posedge clk); #1;
    bus.ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(gen());
      bus.valid_in = 1'b1;
      chk("bp_ready_out", 64'(bus.ready_out), 64'(i < 2));
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    p0 = pops;
    bus.ready_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_drain_count", 64'(pops - p0), 64'd2);
    chk("bp_drain_idle", 64'(bus.valid_out), 64'd0);

    // Randomised traffic with random stalls.
    sent = 0;
    guard = 0;
    while (sent < 400 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      if (took) sent++;
      bus.ready_in = ($urandom_range(0, 3) != 0);
      if (!bus.valid_in || took) begin
        if ($urandom_range(0, 4) != 0) begin
          drive(gen());
          bus.valid_in = 1'b1;
        end else bus.valid_in = 1'b0;
      end
    end
    chk("random_sent", 64'(sent), 64'd400);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 50 && (q.size() != 0 || bus.valid_out); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Reset with two bundles in flight.
    bus.ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(gen());
      bus.valid_in = 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_valid_drop", 64'(bus.valid_out), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst_no_output", 64'(bus.valid_out), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
